// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues sequential fetch requests under a credit limit,
// buffers in-order responses with their PCs, and flushes/re-steers on redirect.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        fetch_idle,
    output logic [1:0]  dbg_state
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        HALT_DRAIN = 2'd1,
        HALTED     = 2'd2
    } state_e;

    state_e        state_q;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [31:0]   inst_mem_q [DEPTH];
    logic [31:0]   pc_mem_q   [DEPTH];

    logic          req_fire, resp_fire, push, pop;
    logic [CW:0]   credit_used;
    logic [31:0]   redirect_pc_aligned;

    // Handshakes: a transfer happens in a cycle where valid && ready are both high at the
    // rising edge; a raised request holds addr/valid until accepted, except under redirect.
    assign credit_used         = {1'b0, count_q} + {1'b0, inflight_q};
    assign redirect_pc_aligned = redirect_pc & 32'hFFFF_FFFC;

    assign imem_req_valid = reset && (state_q == RUN) && !redirect_valid && (credit_used < DEPTH_W);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign resp_fire = imem_resp_valid && (inflight_q != '0);
    assign push      = resp_fire && (drop_q == '0) && !redirect_valid;

    assign inst_valid = (count_q != '0);
    assign pop        = inst_valid && inst_ready && !redirect_valid;
    assign inst       = inst_valid ? inst_mem_q[head_q] : 32'h0;
    assign inst_pc    = inst_valid ? pc_mem_q[head_q]   : 32'h0;

    assign fetch_idle = (state_q == HALTED);
    assign dbg_state  = state_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        if (redirect_valid) begin
            // Everything still in flight becomes stale, including responses already
            // marked for dropping, so drop is set to the in-flight count, not accumulated.
            fetch_pc_d = redirect_pc_aligned;
            resp_pc_d  = redirect_pc_aligned;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            inflight_d = inflight_q - CW'(resp_fire);
            drop_d     = inflight_q - CW'(resp_fire);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
            inflight_d = inflight_q + CW'(req_fire) - CW'(resp_fire);
            if (resp_fire && (drop_q != '0)) drop_d = drop_q - CW'(1);
            if (push) begin
                tail_d    = tail_q + PW'(1);
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (pop) head_d = head_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[tail_q] <= imem_resp_data;
            pc_mem_q[tail_q]   <= resp_pc_q;
        end
    end

    // Redirects never change the run state; only halt_req and the drain condition do.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            case (state_q)
                RUN:        if (halt_req) state_q <= HALT_DRAIN;
                HALT_DRAIN: begin
                    if (!halt_req) state_q <= RUN;
                    else if ((inflight_q == '0) && (count_q == '0)) state_q <= HALTED;
                end
                HALTED:     if (!halt_req) state_q <= RUN;
                default:    state_q <= RUN;
            endcase
        end
    end

endmodule
